// File: rtl/dec_hazard_ctrl_pkg.sv
// dec_hazard_ctrl_pkg: shared FSM encodings, CSR funct3 constant and opcode values for the decode hazard controller.
package dec_hazard_ctrl_pkg;
  typedef enum logic {HZ_IDLE = 1'b0, HZ_FLUSH = 1'b1} hz_state_e;
  localparam logic [2:0] CSR_FUNCT3_NONE = 3'b000;
  localparam logic [6:0] INST_LOAD   = 7'b0000011;
  localparam logic [6:0] INST_BRANCH = 7'b1100011;
  localparam logic [6:0] INST_SYSTEM = 7'b1110011;
  function automatic logic is_csr_op(input logic is_system, input logic [2:0] funct3);
    return is_system & (funct3 != CSR_FUNCT3_NONE);
  endfunction
endpackage

// File: rtl/dec_hazard_ctrl_tracker.sv
// hazard_inflight_tracker: shift-register record of issued instructions (and which were CSRs) until they retire at the MSB.
module hazard_inflight_tracker #(
  parameter int DRAIN_DEPTH = 3
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic en,
  input  logic in_vld,
  input  logic in_csr,
  output logic any_vld,
  output logic any_csr
);
  logic [DRAIN_DEPTH-1:0] vld, csr;
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld <= '0;
      csr <= '0;
    end else if (en) begin
      vld <= {vld[DRAIN_DEPTH-2:0], in_vld};
      csr <= {csr[DRAIN_DEPTH-2:0], in_csr};
    end
  end
  assign any_vld = |vld;
  assign any_csr = |csr;
endmodule

// File: rtl/dec_hazard_ctrl.sv
// dec_hazard_ctrl: decode hazard controller (load-use, redirect flush, CSR drain, memory stall).
// Define HAZ_PERF_CNT_EN to add 32-bit per-control event counters.
module dec_hazard_ctrl
  import dec_hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC   = 2,
  parameter int DRAIN_DEPTH = 3
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       dec_inst_vld,
  input  logic [4:0] dec_rs1,
  input  logic [4:0] dec_rs2,
  input  logic       dec_rs1_ren,
  input  logic       dec_rs2_ren,
  input  logic       dec_is_system,
  input  logic [2:0] dec_funct3,
  input  logic [4:0] ex_rd,
  input  logic       ex_rd_wen,
  input  logic       ex_is_load,
  input  logic       br_taken,
  input  logic       mem_stall,
  output logic       dec_freeze,
  output logic       nop_insert,
  output logic       alu_flush,
  output logic       csr_hazard,
  output logic       pc_hold
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_cnt,
  output logic [31:0] perf_csr_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_freeze_cnt
`endif
);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYC - 1);
  hz_state_e state, state_nx;
  logic [1:0] flush_cnt, flush_cnt_nx;
  logic act, run, is_csr, load_use, csr_raw, issue, any_vld, any_csr;
  // act keeps every control quiet during reset and the first cycle after release
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      act       <= 1'b0;
      state     <= HZ_IDLE;
      flush_cnt <= 2'd0;
    end else begin
      act       <= 1'b1;
      state     <= state_nx;
      flush_cnt <= flush_cnt_nx;
    end
  end
  assign run    = act & ~mem_stall;
  assign is_csr = is_csr_op(dec_is_system, dec_funct3);
  assign load_use = dec_inst_vld & ex_is_load & ex_rd_wen & (ex_rd != 5'd0) &
                    ((dec_rs1_ren & (dec_rs1 == ex_rd)) | (dec_rs2_ren & (dec_rs2 == ex_rd)));
  assign csr_raw  = dec_inst_vld & ((is_csr & any_vld) | any_csr);
  // FLUSH holds the registered tail; the redirect cycle itself is covered by br_taken directly
  always_comb begin
    state_nx     = state;
    flush_cnt_nx = flush_cnt;
    if (run) begin
      if (br_taken && FLUSH_CYC > 1) begin
        state_nx     = HZ_FLUSH;
        flush_cnt_nx = FLUSH_LOAD;
      end else if (state == HZ_FLUSH) begin
        state_nx     = (flush_cnt <= 2'd1) ? HZ_IDLE : HZ_FLUSH;
        flush_cnt_nx = (flush_cnt <= 2'd1) ? 2'd0 : flush_cnt - 2'd1;
      end
    end
  end
  assign dec_freeze = act & mem_stall;
  assign alu_flush  = run & (br_taken | (state == HZ_FLUSH));
  assign csr_hazard = run & ~alu_flush & csr_raw;
  assign nop_insert = run & ~alu_flush & ~csr_hazard & load_use;
  assign pc_hold    = dec_freeze | csr_hazard | nop_insert;
  assign issue      = run & dec_inst_vld & ~alu_flush & ~csr_hazard & ~nop_insert;
  hazard_inflight_tracker #(.DRAIN_DEPTH(DRAIN_DEPTH)) u_trk (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .en      (run),
    .in_vld  (issue),
    .in_csr  (issue & is_csr),
    .any_vld (any_vld),
    .any_csr (any_csr)
  );
`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      perf_lu_cnt     <= '0;
      perf_csr_cnt    <= '0;
      perf_flush_cnt  <= '0;
      perf_freeze_cnt <= '0;
    end else begin
      perf_lu_cnt     <= perf_lu_cnt + 32'(nop_insert);
      perf_csr_cnt    <= perf_csr_cnt + 32'(csr_hazard);
      perf_flush_cnt  <= perf_flush_cnt + 32'(alu_flush);
      perf_freeze_cnt <= perf_freeze_cnt + 32'(dec_freeze);
    end
  end
`endif
endmodule
